// File: rtl/pwm_bank.sv
// Bank of PWM generators sharing one prescaled period counter; duty targets are
// written at any time and committed (directly or slewed) only at period boundaries.
module pwm_bank #(
    parameter int CHANNELS  = 10,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 98,
    parameter int RAMP_EN   = 0,
    parameter int RAMP_STEP = 1,
    parameter int STAGGER   = 0,
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk25M,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_ack,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [AW:0]    CH_LIM    = (AW + 1)'(CHANNELS);
    localparam logic [WIDTH:0] STEP_W    = (WIDTH + 1)'(RAMP_STEP);

    logic [PW-1:0]       presc_q, presc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                step;
    logic                wr_hit;
    logic                wr_ack_q;
    logic [WIDTH-1:0]    target_q [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    // Moves cur toward tgt by at most RAMP_STEP without overshooting.
    function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return ({1'b0, diff} > STEP_W) ? cur + STEP_W[WIDTH-1:0] : tgt;
        end else begin
            diff = cur - tgt;
            return ({1'b0, diff} > STEP_W) ? cur - STEP_W[WIDTH-1:0] : tgt;
        end
    endfunction

    assign step        = (presc_q == PRESC_MAX);
    assign period_tick = step & (&cnt_q) & ~rst;
    assign wr_hit      = wr_en & ({1'b0, wr_addr} < CH_LIM);

    always_comb begin
        presc_d = step ? '0 : presc_q + 1'b1;
        cnt_d   = step ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            wr_ack_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) target_q[i] <= '0;
        end else begin
            wr_ack_q <= wr_hit;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit && (wr_addr == AW'(i))) target_q[i] <= wr_data;
            end
        end
    end

    // active_q reads the pre-write target, so a write landing on the tick waits a period.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_d[i] = active_q[i];
            if (period_tick) active_d[i] = (RAMP_EN != 0) ? slew(active_q[i], target_q[i]) : target_q[i];
        end
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) active_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) active_q[i] <= active_d[i];
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [WIDTH-1:0] OFF = (STAGGER != 0) ? WIDTH'((i * (2 ** WIDTH)) / CHANNELS) : '0;
        logic [WIDTH-1:0] ph;
        assign ph       = cnt_q + OFF;
        assign pwm_d[i] = ch_en[i] & (ph < active_q[i]);
    end

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end

    assign pwm_out = pwm_q;
    assign wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Four pwm_bank instances (plain, ramped, prescaled, staggered) checked every cycle
// against a cycle-count based model, plus directed period-level measurements.
module tb_pwm_bank;

    logic clk25M = 1'b0;
    always #5 clk25M = ~clk25M;

    logic       rst = 1'b0;
    logic       wr_en_a = 1'b0;
    logic [3:0] wr_addr_a = '0;
    logic [7:0] wr_data_a = '0;
    logic [9:0] ch_en_a = '1;
    logic       wr_en_s = 1'b0;
    logic [1:0] wr_addr_s = '0;
    logic [7:0] wr_data_s = '0;
    logic [3:0] ch_en_s = '1;

    logic [3:0] ack_o, tick_o;
    logic [9:0] pwm_a, pwm_r, pwm_p;
    logic [3:0] pwm_s;

    pwm_bank #(.CHANNELS(10), .WIDTH(8), .PRESCALE(1), .RAMP_EN(0), .RAMP_STEP(1), .STAGGER(0)) dut_a (
        .clk25M(clk25M), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .wr_ack(ack_o[0]), .ch_en(ch_en_a), .pwm_out(pwm_a), .period_tick(tick_o[0]));
    pwm_bank #(.CHANNELS(10), .WIDTH(8), .PRESCALE(1), .RAMP_EN(1), .RAMP_STEP(16), .STAGGER(0)) dut_r (
        .clk25M(clk25M), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .wr_ack(ack_o[1]), .ch_en(ch_en_a), .pwm_out(pwm_r), .period_tick(tick_o[1]));
    pwm_bank #(.CHANNELS(10), .WIDTH(8), .PRESCALE(3), .RAMP_EN(0), .RAMP_STEP(1), .STAGGER(0)) dut_p (
        .clk25M(clk25M), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .wr_ack(ack_o[2]), .ch_en(ch_en_a), .pwm_out(pwm_p), .period_tick(tick_o[2]));
    pwm_bank #(.CHANNELS(4), .WIDTH(8), .PRESCALE(1), .RAMP_EN(0), .RAMP_STEP(1), .STAGGER(1)) dut_s (
        .clk25M(clk25M), .rst(rst), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .wr_ack(ack_o[3]), .ch_en(ch_en_s), .pwm_out(pwm_s), .period_tick(tick_o[3]));

    int m_ch[4]   = '{10, 10, 10, 4};
    int m_p[4]    = '{1, 1, 3, 1};
    int m_ramp[4] = '{0, 1, 0, 0};
    int m_stg[4]  = '{0, 0, 0, 1};

    int        tgt[4][16];
    int        act[4][16];
    int        t[4];
    bit [15:0] epwm[4];
    bit [3:0]  eack;

    int n_tests = 0;
    int n_fail  = 0;
    int hc[16];
    int rise[4];
    int ramp_exp[8] = '{16, 32, 48, 64, 80, 96, 100, 100};

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t got=%0h want=%0h", nm, d, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] get_pwm(input int d);
        case (d)
            0:       return {6'b0, pwm_a};
            1:       return {6'b0, pwm_r};
            2:       return {6'b0, pwm_p};
            default: return {12'b0, pwm_s};
        endcase
    endfunction

    function automatic int slew(input int cur, input int tg);
        if (tg > cur) return (tg - cur > 16) ? cur + 16 : tg;
        return (cur - tg > 16) ? cur - 16 : tg;
    endfunction

    // One clock edge of the abstract model: everything derives from t, the edges since reset.
    task automatic model_step(input int d);
        int cnt, ph, wa, wd;
        bit tk, we;
        logic [15:0] en;
        cnt = (t[d] / m_p[d]) % 256;
        tk  = ((t[d] % m_p[d]) == m_p[d] - 1) && (cnt == 255);
        we  = (d == 3) ? wr_en_s : wr_en_a;
        wa  = (d == 3) ? int'(wr_addr_s) : int'(wr_addr_a);
        wd  = (d == 3) ? int'(wr_data_s) : int'(wr_data_a);
        en  = (d == 3) ? {12'b0, ch_en_s} : {6'b0, ch_en_a};
        for (int i = 0; i < m_ch[d]; i++) begin
            ph = (cnt + ((m_stg[d] != 0) ? (i * 256) / m_ch[d] : 0)) % 256;
            epwm[d][i] = en[i] && (ph < act[d][i]);
        end
        if (tk) begin
            for (int i = 0; i < m_ch[d]; i++)
                act[d][i] = (m_ramp[d] != 0) ? slew(act[d][i], tgt[d][i]) : tgt[d][i];
        end
        eack[d] = we && (wa < m_ch[d]);
        if (eack[d]) tgt[d][wa] = wd;
        t[d]++;
    endtask

    initial begin
        forever begin
            @(posedge clk25M or posedge rst);
            if (rst) begin
                for (int d = 0; d < 4; d++) begin
                    for (int i = 0; i < 16; i++) begin
                        tgt[d][i] = 0;
                        act[d][i] = 0;
                    end
                    t[d] = 0;
                    epwm[d] = '0;
                end
                eack = '0;
            end else begin
                for (int d = 0; d < 4; d++) model_step(d);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk25M);
            for (int d = 0; d < 4; d++) begin
                chk("pwm_out", d, 32'(get_pwm(d)), 32'(epwm[d]));
                chk("wr_ack", d, 32'(ack_o[d]), 32'(eack[d]));
                chk("period_tick", d, 32'(tick_o[d]),
                    32'(!rst && ((t[d] % m_p[d]) == m_p[d] - 1) && (((t[d] / m_p[d]) % 256) == 255)));
            end
        end
    end

    task automatic write_a(input int addr, input int data, input bit exp_ack);
        wr_en_a = 1'b1; wr_addr_a = 4'(addr); wr_data_a = 8'(data);
        @(posedge clk25M); #1;
        wr_en_a = 1'b0;
        chk("ack_after_write", 0, 32'(ack_o[0]), 32'(exp_ack));
    endtask

    task automatic write_s(input int addr, input int data);
        wr_en_s = 1'b1; wr_addr_s = 2'(addr); wr_data_s = 8'(data);
        @(posedge clk25M); #1;
        wr_en_s = 1'b0;
        chk("ack_after_write_s", 3, 32'(ack_o[3]), 32'd1);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk25M);
            n++;
        end while (!tick_o[0] && n < 1000);
        if (!tick_o[0]) chk("tick_timeout", 0, 32'd0, 32'd1);
    endtask

    // Counts high cycles of dut d over 256 samples; also logs rising-edge sample index for dut_s.
    task automatic count_period(input int d);
        logic [15:0] v;
        logic [3:0]  prev;
        for (int i = 0; i < 16; i++) hc[i] = 0;
        for (int i = 0; i < 4; i++) rise[i] = -1;
        prev = pwm_s;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk25M);
            v = get_pwm(d);
            for (int i = 0; i < 16; i++) if (v[i]) hc[i]++;
            for (int i = 0; i < 4; i++) if (pwm_s[i] && !prev[i]) rise[i] = k;
            prev = pwm_s;
        end
    endtask

    task automatic first_tick_after_release();
        int n;
        @(posedge clk25M); #1;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk25M);
            n++;
        end while (!tick_o[0] && n < 1000);
        chk("first_tick_delay", 0, 32'(n), 32'd256);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_pwm", 0, 32'({pwm_a, pwm_s}), 32'd0);
        chk("reset_ack_tick", 0, 32'({ack_o, tick_o}), 32'd0);
        repeat (3) @(posedge clk25M);
        first_tick_after_release();
        @(negedge clk25M);

        write_a(3, 64, 1'b1);
        @(posedge clk25M); #1;
        chk("ack_single_pulse", 0, 32'(ack_o[0]), 32'd0);
        write_a(0, 200, 1'b1);
        for (int i = 0; i < 4; i++) write_s(i, 128);
        wait_tick();
        @(negedge clk25M);
        count_period(0);
        chk("duty64_ch3", 0, 32'(hc[3]), 32'd64);
        chk("duty200_ch0", 0, 32'(hc[0]), 32'd200);

        write_a(0, 0, 1'b1);
        write_a(1, 255, 1'b1);
        wait_tick();
        @(negedge clk25M);
        count_period(0);
        chk("duty0_ch0", 0, 32'(hc[0]), 32'd0);
        chk("duty255_ch1", 0, 32'(hc[1]), 32'd255);
        for (int i = 1; i < 4; i++)
            chk("stagger_offset", 3, 32'((rise[i] - rise[0] + 256) % 256), 32'((256 - 64 * i) % 256));

        write_a(2, 100, 1'b1);
        wait_tick();
        @(negedge clk25M);
        for (int p = 0; p < 8; p++) begin
            count_period(1);
            chk("ramp_step", 1, 32'(hc[2]), 32'(ramp_exp[p]));
        end

        wait_tick();
        write_a(3, 192, 1'b1);
        @(negedge clk25M);
        count_period(0);
        chk("tick_write_old", 0, 32'(hc[3]), 32'd64);
        count_period(0);
        chk("tick_write_new", 0, 32'(hc[3]), 32'd192);
        ch_en_a[3] = 1'b0;
        count_period(0);
        chk("ch_en_off", 0, 32'(hc[3]), 32'd0);
        ch_en_a[3] = 1'b1;
        count_period(0);
        chk("ch_en_resume", 0, 32'(hc[3]), 32'd192);
        write_a(10, 77, 1'b0);
        @(posedge clk25M); #1;
        chk("bad_addr_no_ack", 0, 32'(ack_o), 32'd0);

        repeat (100) @(posedge clk25M);
        #1 rst = 1'b1;
        #1;
        chk("midrst_pwm", 0, 32'({pwm_a, pwm_r, pwm_p, pwm_s}), 32'd0);
        chk("midrst_ack_tick", 0, 32'({ack_o, tick_o}), 32'd0);
        repeat (3) @(posedge clk25M);
        first_tick_after_release();
        @(negedge clk25M);
        count_period(1);
        chk("rst_clears_ramp", 1, 32'(hc[2]), 32'd0);
        chk("rst_clears_target", 1, 32'(hc[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CHANNELS, 10, number of PWM channels (1..16).
- WIDTH, 8, duty/counter resolution in bits (4..16).
- PRESCALE, 98, clk25M cycles per counter step (>=1).
- RAMP_EN, 0, 1 = duty slews toward target; 0 = target applied directly.
- RAMP_STEP, 1, maximum duty change per PWM period when RAMP_EN=1.
- STAGGER, 0, 1 = channel phase offsets enabled.

REQ-002 Ports, one per line: name, direction, width, meaning. AW = max(1, clog2(CHANNELS)).
- clk25M, in, 1, sole clock; all logic is rising-edge.
- rst, in, 1, asynchronous reset, active-high.
- wr_en, in, 1, write strobe for a duty target.
- wr_addr, in, AW, channel index.
- wr_data, in, WIDTH, target duty.
- wr_ack, out, 1, one-cycle acknowledge of an accepted write.
- ch_en, in, CHANNELS, per-channel output enable.
- pwm_out, out, CHANNELS, registered PWM outputs.
- period_tick, out, 1, one-cycle pulse at each PWM period boundary.

Function
REQ-003 The prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert an internal step strobe in the cycle in which it holds PRESCALE-1.
REQ-004 The WIDTH-bit period counter cnt SHALL increment on each step strobe and wrap from 2^WIDTH-1 to 0; one period is PRESCALE*2^WIDTH clk25M cycles.
REQ-005 period_tick SHALL be high for exactly one cycle: the cycle in which cnt = 2^WIDTH-1 and the step strobe are both asserted.
REQ-006 A write with wr_en=1 and wr_addr<CHANNELS SHALL load target[wr_addr] at that clock edge, and wr_ack SHALL be high in the following cycle only.
REQ-007 A write with wr_addr>=CHANNELS SHALL be ignored, with no wr_ack and no state change; back-to-back writes SHALL be accepted every cycle.
REQ-008 active[i] SHALL update only on period_tick cycles. Updates never occur mid-period, so outputs are glitch-free.
REQ-009 If RAMP_EN=0, active[i] SHALL take target[i] on period_tick.
REQ-010 If RAMP_EN=1, on period_tick active[i] SHALL move toward target[i] by min(RAMP_STEP, |target-active|), with no overshoot and no wrap.
REQ-011 If a write and period_tick occur in the same cycle, the commit SHALL use the pre-write target, and the new value SHALL commit at the next period_tick.
REQ-012 Each channel SHALL compare a phase value ph[i] against its duty:
- STAGGER=0: ph[i] = cnt.
- STAGGER=1: ph[i] = (cnt + floor(i*2^WIDTH/CHANNELS)) mod 2^WIDTH.
REQ-013 The registered output SHALL be pwm_out[i] = ch_en[i] AND (ph[i] < active[i]), with one clk25M cycle of latency from cnt/active/ch_en to the output.
REQ-014 Duty boundary values:
- active=0 gives a constant low output.
- active=2^WIDTH-1 gives output high for all but one count per period.
REQ-015 Deasserting ch_en[i] SHALL force pwm_out[i] low on the next edge while target[i] and active[i] are retained; reasserting it SHALL resume output in phase.

Reset
REQ-016 While rst=1, the following SHALL be 0 immediately (asynchronously): prescaler, cnt, all target[i], all active[i], pwm_out, wr_ack, period_tick.
REQ-017 Reset release SHALL be synchronous to clk25M, and counting SHALL start on the first edge after rst falls.
REQ-018 Reset asserted mid-period or mid-ramp SHALL abandon all progress; no write SHALL be acknowledged while rst=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios (WIDTH=8 and PRESCALE=1 unless stated):
- Write ch3=64, then wait 2 periods -> pwm_out[3] high for exactly 64 of 256 cycles; wr_ack pulses once, 1 cycle after the write.
- Write ch0=0 and ch1=255 -> pwm_out[0] constantly low; pwm_out[1] low for 1 cycle per 256.
- RAMP_EN=1, RAMP_STEP=16, write ch2=100 from 0 -> active goes 16, 32, ..., 96, 100 over 7 period_ticks and then holds.
- Write on the same cycle as period_tick -> old duty holds one more full period, new duty appears the next period; wr_addr=CHANNELS gives no ack.
- STAGGER=1, CHANNELS=4, all duty=128 -> rising edges of ch0..ch3 separated by 64 cycles.
- Assert rst mid-period with ch_en=all ones -> all outputs low in the same cycle; after release, period_tick first fires 256 cycles later (PRESCALE=1).
